jam_perm_gen: RTL and testbench
===============================

// Module: jam_perm_gen
// PURPOSE
//  Upstream stage of the job-assignment cost engine. Walks all N! worker->job
//  permutations in lexicographic order, starting at the identity and ending at
//  the fully reversed order. Each permutation goes to the cost calculator on
//  'arrange'; the block then issues a start pulse and waits for its done pulse
//  before computing the next permutation. finish pulses once after the last one.
// PARAMETERS
//  N    8  number of workers/jobs (2..8)
//  IW   3  width of one job index; must satisfy 2**IW >= N
//  CW  16  width of perm_cnt; must hold N! (40320 for N=8)
// PORTS
//  CLK         in   1     clock, rising edge
//  RST         in   1     synchronous active-high reset
//  en          in   1     start a full enumeration; sampled only in IDLE
//  cost_done   in   1     one-cycle pulse from cost calculator: current perm consumed
//  cost_start  out  1     one-cycle pulse: 'arrange' is valid, begin costing
//  arrange     out  N*IW  arrange[k*IW +: IW] = job assigned to worker k
//  perm_cnt    out  CW    permutations issued in this run (count of cost_start pulses)
//  busy        out  1     high in every state except IDLE
//  finish      out  1     one-cycle pulse after cost_done of the last permutation
// BEHAVIOUR
//  Reset, and the IDLE entry: cost_start=0, finish=0, busy=0, perm_cnt=0,
//   arrange=identity (worker k -> job k).
//  RST has priority over all other inputs.
//  RST mid-run: next cycle is IDLE with the reset values above. No pulse is emitted.
//  FSM (one action per cycle):
//   IDLE   : if en -> INIT; else stay.
//   INIT   : arrange=identity, perm_cnt=0 -> ISSUE.
//   ISSUE  : cost_start=1 for exactly this cycle, perm_cnt+=1 -> WAIT.
//   WAIT   : hold arrange stable. On cost_done -> PIVOT, with i=N-2.
//   PIVOT  : if a[i]<a[i+1] -> SUCC, with j=N-1.
//            else if i==0 -> FINISH (no next permutation).
//            else i-=1, stay.
//   SUCC   : if a[j]>a[i] -> SWAP; else j-=1, stay.
//            Termination is guaranteed because a[i+1]>a[i].
//   SWAP   : exchange a[i] and a[j]; set l=i+1, r=N-1 -> REV.
//   REV    : if l<r, exchange a[l] and a[r], l+=1, r-=1, stay.
//            else -> ISSUE.
//   FINISH : finish=1 for exactly this cycle -> IDLE.
//            arrange keeps the last permutation until IDLE restores the identity.
//  Handshake rules:
//   - cost_start is never reasserted before the cost_done for the prior pulse.
//   - cost_done outside WAIT is ignored.
//   - arrange changes only in INIT, SWAP, REV and IDLE entry.
//   - en outside IDLE is ignored.
//   - en held high across FINISH starts a new run (IDLE->INIT).
//  Latency from cost_done to the next cost_start is bounded:
//   <= (N-1) PIVOT + (N-1) SUCC + 1 SWAP + (N/2+1) REV + 1 ISSUE cycles.
//  Width rules:
//   - index counters i, j, l, r are IW+1 bits so the decrements never wrap.
//   - perm_cnt saturates at its max value (no wrap).
//  Final perm_cnt = N!.
// TESTING
//  1 N=3, IW=2; en pulse, cost_done 2 cycles after each cost_start
//    -> arrange 012,021,102,120,201,210; finish once; perm_cnt=6.
//  2 N=8; en pulse, cost_done 1 cycle after each cost_start
//    -> 40320 cost_start pulses, all permutations distinct;
//       last arrange = 7,6,5,4,3,2,1,0; then finish; perm_cnt=40320.
//  3 Hold cost_done low for 50 cycles after one cost_start
//    -> arrange stable, no further cost_start, busy=1 throughout.
//  4 cost_done and en pulses while in IDLE, and a second en during WAIT
//    -> no state change; perm_cnt unchanged.
//  5 RST for 1 cycle at perm_cnt=100, while in REV
//    -> next cycle: IDLE, arrange=identity, perm_cnt=0, busy=0, no finish pulse.
//  6 en held high through a full N=3 run
//    -> finish, one IDLE cycle, then INIT; second run restarts at arrange 012.

Source files
------------

// File: rtl/jam_perm_gen.sv
// jam_perm_gen: walks all N! job orders in lexicographic order,
// handing each one to the cost calculator over a start/done handshake.
module jam_perm_gen #(
    parameter int N  = 8,
    parameter int IW = 3,
    parameter int CW = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            en,
    input  logic            cost_done,
    output logic            cost_start,
    output logic [N*IW-1:0] arrange,
    output logic [CW-1:0]   perm_cnt,
    output logic            busy,
    output logic            finish
);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        ISSUE,
        WAIT,
        PIVOT,
        SUCC,
        SWAP,
        REV,
        FINISH
    } state_t;

    localparam logic [IW:0] ONE  = (IW+1)'(1);
    localparam logic [IW:0] LAST = (IW+1)'(N-1);
    localparam logic [IW:0] PEN  = (IW+1)'(N-2);

    state_t state, state_n;

    logic [IW-1:0] a [N];
    logic [IW:0]   i, j, l, r;
    logic [IW-1:0] ai, ai1, aj, al, ar;

    assign ai  = a[i[IW-1:0]];
    assign ai1 = a[i[IW-1:0] + IW'(1)];
    assign aj  = a[j[IW-1:0]];
    assign al  = a[l[IW-1:0]];
    assign ar  = a[r[IW-1:0]];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign arrange[g*IW +: IW] = a[g];
    end

    assign cost_start = (state == ISSUE);
    assign finish     = (state == FINISH);
    assign busy       = (state != IDLE);

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   if (en) state_n = INIT;
            INIT:   state_n = ISSUE;
            ISSUE:  state_n = WAIT;
            WAIT:   if (cost_done) state_n = PIVOT;
            PIVOT: begin
                if (ai < ai1)
                    state_n = SUCC;
                else if (i == '0)
                    state_n = FINISH;
            end
            SUCC:   if (aj > ai) state_n = SWAP;
            SWAP:   state_n = REV;
            REV:    if (!(l < r)) state_n = ISSUE;
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            perm_cnt <= '0;
            i        <= '0;
            j        <= '0;
            l        <= '0;
            r        <= '0;
            for (int k = 0; k < N; k++)
                a[k] <= IW'(k);
        end else begin
            state <= state_n;
            unique case (state)
                // FINISH preloads the identity so IDLE shows it on entry
                IDLE, INIT, FINISH: begin
                    perm_cnt <= '0;
                    for (int k = 0; k < N; k++)
                        a[k] <= IW'(k);
                end
                ISSUE: begin
                    if (perm_cnt != '1)
                        perm_cnt <= perm_cnt + CW'(1);
                end
                WAIT: begin
                    i <= PEN;
                end
                PIVOT: begin
                    if (ai < ai1)
                        j <= LAST;
                    else if (i != '0)
                        i <= i - ONE;
                end
                SUCC: begin
                    if (!(aj > ai))
                        j <= j - ONE;
                end
                SWAP: begin
                    a[i[IW-1:0]] <= aj;
                    a[j[IW-1:0]] <= ai;
                    l <= i + ONE;
                    r <= LAST;
                end
                REV: begin
                    if (l < r) begin
                        a[l[IW-1:0]] <= ar;
                        a[r[IW-1:0]] <= al;
                        l <= l + ONE;
                        r <= r - ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_jam_perm_gen.sv
// Bench for jam_perm_gen: three sizes (N=3, N=6 with a narrow counter,
// N=8) checked against a factorial-number-system permutation model.
module tb_jam_perm_gen;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic en = 1'b0;
    logic cost_done = 1'b0;
    int   sel = 0;

    always #5 CLK = ~CLK;

    logic en3, cd3, cs3, busy3, fin3;
    logic [5:0] arr3;
    logic [3:0] cnt3;
    logic en6, cd6, cs6, busy6, fin6;
    logic [17:0] arr6;
    logic [8:0] cnt6;
    logic en8, cd8, cs8, busy8, fin8;
    logic [23:0] arr8;
    logic [15:0] cnt8;

    assign en3 = (sel == 0) & en;
    assign cd3 = (sel == 0) & cost_done;
    assign en6 = (sel == 1) & en;
    assign cd6 = (sel == 1) & cost_done;
    assign en8 = (sel == 2) & en;
    assign cd8 = (sel == 2) & cost_done;

    jam_perm_gen #(.N(3), .IW(2), .CW(4)) dut3 (
        .CLK(CLK), .RST(RST), .en(en3), .cost_done(cd3),
        .cost_start(cs3), .arrange(arr3), .perm_cnt(cnt3),
        .busy(busy3), .finish(fin3)
    );
    jam_perm_gen #(.N(6), .IW(3), .CW(9)) dut6 (
        .CLK(CLK), .RST(RST), .en(en6), .cost_done(cd6),
        .cost_start(cs6), .arrange(arr6), .perm_cnt(cnt6),
        .busy(busy6), .finish(fin6)
    );
    jam_perm_gen #(.N(8), .IW(3), .CW(16)) dut8 (
        .CLK(CLK), .RST(RST), .en(en8), .cost_done(cd8),
        .cost_start(cs8), .arrange(arr8), .perm_cnt(cnt8),
        .busy(busy8), .finish(fin8)
    );

    logic        o_start, o_busy, o_fin;
    logic [23:0] o_arr;
    logic [15:0] o_cnt;

    always_comb begin
        o_start = 1'b0;
        o_busy  = 1'b0;
        o_fin   = 1'b0;
        o_arr   = '0;
        o_cnt   = '0;
        case (sel)
            0: begin
                o_start = cs3; o_busy = busy3; o_fin = fin3;
                o_arr = 24'(arr3); o_cnt = 16'(cnt3);
            end
            1: begin
                o_start = cs6; o_busy = busy6; o_fin = fin6;
                o_arr = 24'(arr6); o_cnt = 16'(cnt6);
            end
            default: begin
                o_start = cs8; o_busy = busy8; o_fin = fin8;
                o_arr = arr8; o_cnt = cnt8;
            end
        endcase
    end

    int NS[3]  = '{3, 6, 8};
    int IWS[3] = '{2, 3, 3};
    int CMX[3] = '{15, 511, 65535};

    int checks = 0;
    int errors = 0;

    int r_count, r_seq_bad, r_dup, r_cnt_bad, r_lat_bad, r_hs_bad;
    bit r_fin;
    logic [23:0] r_fin_arr, r_bad_exp, r_bad_act;
    logic [15:0] r_fin_cnt;

    function automatic int fact(input int n);
        int f = 1;
        for (int k = 2; k <= n; k++) f *= k;
        return f;
    endfunction

    // k-th permutation in lexicographic order via factorial digits
    function automatic void kth_arr(input int n, input int k, output int p[8]);
        int avail[$];
        int f, idx;
        for (int x = 0; x < 8; x++) p[x] = 0;
        for (int x = 0; x < n; x++) avail.push_back(x);
        for (int pos = 0; pos < n; pos++) begin
            f = fact(n - 1 - pos);
            idx = k / f;
            k = k % f;
            p[pos] = avail[idx];
            avail.delete(idx);
        end
    endfunction

    function automatic logic [23:0] pack(input int p[8], input int n, input int iw);
        logic [23:0] v = '0;
        for (int x = 0; x < n; x++) v |= 24'(p[x]) << (x * iw);
        return v;
    endfunction

    function automatic logic [23:0] kth_pack(input int n, input int iw, input int k);
        int p[8];
        kth_arr(n, k, p);
        return pack(p, n, iw);
    endfunction

    // drives one enumeration and gathers statistics for the caller to judge
    task automatic run_enum(input int s, input int dmin, input int dmax,
                            input bit en_noise, input bit hold, input int stop_at);
        int n, iw, cmax, total, bound, budget, cyc, lat, d, want;
        logic [23:0] exp_v, held;
        bit seen [logic [23:0]];
        n = NS[s];
        iw = IWS[s];
        cmax = CMX[s];
        total = fact(n);
        bound = 2 * (n - 1) + 1 + (n / 2 + 1) + 1;
        budget = total * (dmax + bound + 4) + 20;
        r_count = 0; r_seq_bad = 0; r_dup = 0;
        r_cnt_bad = 0; r_lat_bad = 0; r_hs_bad = 0;
        r_fin = 0; r_fin_arr = '0; r_fin_cnt = '0;
        r_bad_exp = '0; r_bad_act = '0;
        sel = s;
        en = 1'b1;
        @(negedge CLK);
        en = hold;
        cyc = 0;
        lat = -1;
        while (cyc < budget) begin
            if (o_fin) begin
                r_fin = 1;
                r_fin_arr = o_arr;
                r_fin_cnt = o_cnt;
                break;
            end
            if (o_start) begin
                if (lat > bound) r_lat_bad++;
                exp_v = (r_count < total) ? kth_pack(n, iw, r_count) : 24'hffffff;
                if (o_arr !== exp_v) begin
                    if (r_seq_bad == 0) begin
                        r_bad_exp = exp_v;
                        r_bad_act = o_arr;
                    end
                    r_seq_bad++;
                end
                if (seen.exists(o_arr)) r_dup++;
                seen[o_arr] = 1'b1;
                held = o_arr;
                r_count++;
                @(negedge CLK);
                cyc++;
                want = (r_count < cmax) ? r_count : cmax;
                if (o_cnt !== 16'(want)) r_cnt_bad++;
                if (r_count == stop_at) return;
                d = $urandom_range(dmax, dmin);
                for (int w = 1; w < d; w++) begin
                    if (en_noise) en = 1'($urandom_range(1, 0));
                    @(negedge CLK);
                    cyc++;
                    if (o_start || !o_busy || o_arr !== held) r_hs_bad++;
                end
                en = hold;
                cost_done = 1'b1;
                @(negedge CLK);
                cost_done = 1'b0;
                cyc++;
                lat = 1;
            end else begin
                @(negedge CLK);
                cyc++;
                if (lat >= 0) lat++;
            end
        end
    endtask

    task automatic pulse_rst();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        logic [23:0] idv;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            idv = kth_pack(NS[s], IWS[s], 0);
            checks++;
            if (o_busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_busy dut%0d got %0b want 0", s, o_busy);
            end
            checks++;
            if (o_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_cnt dut%0d got %0d want 0", s, o_cnt);
            end
            checks++;
            if (o_arr !== idv) begin
                errors++;
                $display("FAIL reset_arr dut%0d got %h want %h", s, o_arr, idv);
            end
            checks++;
            if ((o_start | o_fin) !== 1'b0) begin
                errors++;
                $display("FAIL reset_pulse dut%0d start %0b fin %0b want 0", s, o_start, o_fin);
            end
        end
        @(negedge CLK);
    endtask

    task automatic test_enum3();
        int stray = 0;
        run_enum(0, 2, 2, 0, 0, 0);
        checks++;
        if (r_fin !== 1'b1 || r_count !== 6) begin
            errors++;
            $display("FAIL e3_count got %0d fin %0b want 6 fin 1", r_count, r_fin);
        end
        checks++;
        if (r_seq_bad !== 0) begin
            errors++;
            $display("FAIL e3_seq got %h want %h (%0d bad)", r_bad_act, r_bad_exp, r_seq_bad);
        end
        checks++;
        if (r_fin_cnt !== 16'd6) begin
            errors++;
            $display("FAIL e3_fin_cnt got %0d want 6", r_fin_cnt);
        end
        checks++;
        if (r_fin_arr !== kth_pack(3, 2, 5)) begin
            errors++;
            $display("FAIL e3_last got %h want %h", r_fin_arr, kth_pack(3, 2, 5));
        end
        checks++;
        if (r_cnt_bad !== 0 || r_hs_bad !== 0) begin
            errors++;
            $display("FAIL e3_hs got cnt %0d hs %0d want 0 0", r_cnt_bad, r_hs_bad);
        end
        @(negedge CLK);
        checks++;
        if (o_busy !== 1'b0 || o_cnt !== 16'd0 || o_arr !== kth_pack(3, 2, 0)) begin
            errors++;
            $display("FAIL e3_idle got busy %0b cnt %0d arr %h want 0 0 identity",
                     o_busy, o_cnt, o_arr);
        end
        repeat (5) begin
            @(negedge CLK);
            if (o_fin || o_start || o_busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL e3_once got %0d stray cycles want 0", stray);
        end
    endtask

    task automatic test_idle_ignore();
        int bad = 0;
        sel = 0;
        cost_done = 1'b1;
        @(negedge CLK);
        cost_done = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (o_busy || o_start || o_cnt !== 16'd0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_done got %0d bad cycles want 0", bad);
        end
        run_enum(0, 2, 5, 1, 0, 0);
        checks++;
        if (r_fin !== 1'b1 || r_count !== 6 || r_seq_bad !== 0) begin
            errors++;
            $display("FAIL wait_en got count %0d fin %0b bad %0d want 6 1 0",
                     r_count, r_fin, r_seq_bad);
        end
        checks++;
        if (r_cnt_bad !== 0 || r_hs_bad !== 0) begin
            errors++;
            $display("FAIL wait_en_hs got cnt %0d hs %0d want 0 0", r_cnt_bad, r_hs_bad);
        end
        @(negedge CLK);
    endtask

    task automatic test_enum6_sat();
        run_enum(1, 1, 3, 1, 0, 0);
        checks++;
        if (r_fin !== 1'b1 || r_count !== 720) begin
            errors++;
            $display("FAIL e6_count got %0d fin %0b want 720 fin 1", r_count, r_fin);
        end
        checks++;
        if (r_seq_bad !== 0 || r_dup !== 0) begin
            errors++;
            $display("FAIL e6_seq got %h want %h (%0d bad %0d dup)",
                     r_bad_act, r_bad_exp, r_seq_bad, r_dup);
        end
        checks++;
        if (r_cnt_bad !== 0 || r_fin_cnt !== 16'd511) begin
            errors++;
            $display("FAIL e6_sat got final %0d (%0d bad) want 511", r_fin_cnt, r_cnt_bad);
        end
        checks++;
        if (r_lat_bad !== 0) begin
            errors++;
            $display("FAIL e6_latency got %0d over bound want 0", r_lat_bad);
        end
        checks++;
        if (r_fin_arr !== kth_pack(6, 3, 719)) begin
            errors++;
            $display("FAIL e6_last got %h want %h", r_fin_arr, kth_pack(6, 3, 719));
        end
        @(negedge CLK);
    endtask

    task automatic test_stall();
        int bad = 0;
        logic [23:0] held;
        run_enum(0, 1, 1, 0, 0, 1);
        held = o_arr;
        repeat (50) begin
            @(negedge CLK);
            if (o_start || !o_busy || o_arr !== held || o_cnt !== 16'd1) bad++;
        end
        checks++;
        if (r_count !== 1 || bad !== 0) begin
            errors++;
            $display("FAIL stall got count %0d bad %0d want 1 0", r_count, bad);
        end
        pulse_rst();
    endtask

    task automatic test_rst_mid();
        int p[8];
        int pi, pj, stray;
        run_enum(2, 1, 1, 0, 0, 100);
        checks++;
        if (r_count !== 100 || r_seq_bad !== 0 || r_cnt_bad !== 0) begin
            errors++;
            $display("FAIL n8_prefix got count %0d bad %0d cnt %0d want 100 0 0",
                     r_count, r_seq_bad, r_cnt_bad);
        end
        kth_arr(8, 99, p);
        pi = 0;
        pj = 7;
        for (int x = 6; x >= 0; x--)
            if (p[x] < p[x+1]) begin pi = x; break; end
        for (int x = 7; x > pi; x--)
            if (p[x] > p[pi]) begin pj = x; break; end
        cost_done = 1'b1;
        @(negedge CLK);
        cost_done = 1'b0;
        repeat ((7 - pi) + (8 - pj) + 1) @(negedge CLK);
        begin
            int t = p[pi];
            p[pi] = p[pj];
            p[pj] = t;
        end
        checks++;
        if (o_arr !== pack(p, 8, 3) || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL rev_arr got %h busy %0b want %h 1", o_arr, o_busy, pack(p, 8, 3));
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (o_busy !== 1'b0 || o_cnt !== 16'd0 || o_arr !== kth_pack(8, 3, 0)) begin
            errors++;
            $display("FAIL rst_mid got busy %0b cnt %0d arr %h want 0 0 %h",
                     o_busy, o_cnt, o_arr, kth_pack(8, 3, 0));
        end
        stray = (o_fin || o_start) ? 1 : 0;
        repeat (4) begin
            @(negedge CLK);
            if (o_fin || o_start || o_busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rst_mid_pulse got %0d stray cycles want 0", stray);
        end
    endtask

    task automatic test_hold_en();
        run_enum(0, 1, 2, 0, 1, 0);
        checks++;
        if (r_fin !== 1'b1 || r_count !== 6 || r_seq_bad !== 0) begin
            errors++;
            $display("FAIL hold_run got count %0d fin %0b bad %0d want 6 1 0",
                     r_count, r_fin, r_seq_bad);
        end
        @(negedge CLK);
        checks++;
        if (o_busy !== 1'b0 || o_arr !== kth_pack(3, 2, 0)) begin
            errors++;
            $display("FAIL hold_idle got busy %0b arr %h want 0 identity", o_busy, o_arr);
        end
        @(negedge CLK);
        checks++;
        if (o_busy !== 1'b1 || o_start !== 1'b0 || o_cnt !== 16'd0) begin
            errors++;
            $display("FAIL hold_init got busy %0b start %0b cnt %0d want 1 0 0",
                     o_busy, o_start, o_cnt);
        end
        @(negedge CLK);
        en = 1'b0;
        checks++;
        if (o_start !== 1'b1 || o_arr !== kth_pack(3, 2, 0)) begin
            errors++;
            $display("FAIL hold_restart got start %0b arr %h want 1 %h",
                     o_start, o_arr, kth_pack(3, 2, 0));
        end
        pulse_rst();
    endtask

    initial begin
        test_reset();
        test_enum3();
        test_idle_ignore();
        test_enum6_sat();
        test_stall();
        test_rst_mid();
        test_hold_en();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
